// File: rtl/fetch_pkg.sv
// Shared processor definitions for the fetch/decode boundary: fetch FSM
// encoding, decode target-select codes, the NOP bubble and PC helpers.
package fetch_pkg;

   typedef enum logic [0:0] {
      ST_REQ  = 1'b0,   // instruction request outstanding
      ST_HOLD = 1'b1    // fetched word buffered while decode is stalled
   } fetch_state_e;

   localparam logic [1:0] SEL_PCIMD2EXT = 2'b00;
   localparam logic [1:0] SEL_PCINDEX   = 2'b01;
   localparam logic [1:0] SEL_REGA      = 2'b10;
   localparam logic [1:0] SEL_RESERVED  = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP   = 32'h0000_0004;

   // Clear the byte-offset bits so every fetch address is word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_target_sel.sv
// Redirect target selection: picks the decode-supplied target for the
// requested control-flow kind and forces it onto a word boundary.
module fetch_target_sel
   import fetch_pkg::*;
(
   input  logic [1:0]  sel,
   input  logic [31:0] pcimd2ext,
   input  logic [31:0] pcindex,
   input  logic [31:0] rega,
   output logic [31:0] target
);

   logic [31:0] raw_s;

   // Select the target source; the reserved code behaves like a branch.
   always_comb begin
      raw_s = pcimd2ext;
      case (sel)
         SEL_PCIMD2EXT: raw_s = pcimd2ext;
         SEL_PCINDEX:   raw_s = pcindex;
         SEL_REGA:      raw_s = rega;
         SEL_RESERVED:  raw_s = pcimd2ext;
         default:       raw_s = pcimd2ext;
      endcase
   end

   assign target = word_align(raw_s);

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues word requests to the memory controller,
// delivers registered instructions to decode, buffers one word while decode
// is stalled and applies delayed (delay-slot) redirects from decode.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fw_if_id_stall,
   input  logic        id_if_selfontepc,
   input  logic [1:0]  id_if_seltipopc,
   input  logic [31:0] id_if_pcimd2ext,
   input  logic [31:0] id_if_pcindex,
   input  logic [31:0] id_if_rega,
   output logic        if_mc_en,
   output logic [31:0] if_mc_addr,
   input  logic [31:0] mc_if_data,
   input  logic        mc_if_ready,
   output logic [31:0] if_id_instrucao,
   output logic [31:0] if_id_proximopc
);

   fetch_state_e state_r;
   fetch_state_e state_next_s;

   logic [31:0] pc_r;
   logic [31:0] pc_plus4_s;
   logic [31:0] next_pc_s;
   logic [31:0] target_s;
   logic        redirect_acc_s;
   logic        req_done_s;

   logic        pend_valid_r;
   logic [31:0] pend_target_r;

   logic [31:0] buf_instr_r;
   logic [31:0] buf_pc4_r;

   logic [31:0] instr_r;
   logic [31:0] pc4_r;

   logic        mc_en_s;

   fetch_target_sel u_target_sel (
      .sel       (id_if_seltipopc),
      .pcimd2ext (id_if_pcimd2ext),
      .pcindex   (id_if_pcindex),
      .rega      (id_if_rega),
      .target    (target_s)
   );

   assign pc_plus4_s     = pc_r + PC_STEP;
   assign redirect_acc_s = id_if_selfontepc & ~fw_if_id_stall;
   assign req_done_s     = (state_r == ST_REQ) & mc_if_ready;

   // Fetch FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_REQ;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Fetch FSM next state: park in HOLD when a word lands during a stall.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_REQ: begin
            if (mc_if_ready && fw_if_id_stall) begin
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_REQ;
            end
         end
         ST_HOLD: begin
            if (!fw_if_id_stall) begin
               state_next_s = ST_REQ;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: state_next_s = ST_REQ;
      endcase
   end

   // Fetch FSM outputs: request only in REQ and never during a reset cycle.
   always_comb begin
      mc_en_s = 1'b0;
      case (state_r)
         ST_REQ: begin
            if (reset) begin
               mc_en_s = 1'b0;
            end else begin
               mc_en_s = 1'b1;
            end
         end
         ST_HOLD: mc_en_s = 1'b0;
         default: mc_en_s = 1'b0;
      endcase
   end

   // Next fetch address: a redirect seen this cycle bypasses the pending one.
   always_comb begin
      next_pc_s = pc_plus4_s;
      if (redirect_acc_s) begin
         next_pc_s = target_s;
      end else if (pend_valid_r) begin
         next_pc_s = pend_target_r;
      end else begin
         next_pc_s = pc_plus4_s;
      end
   end

   // PC advances only when a request completes; otherwise redirects wait.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_r          <= RESET_PC;
         pend_valid_r  <= 1'b0;
         pend_target_r <= 32'h0000_0000;
      end else if (req_done_s) begin
         pc_r         <= next_pc_s;
         pend_valid_r <= 1'b0;
      end else if (redirect_acc_s) begin
         pend_valid_r  <= 1'b1;
         pend_target_r <= target_s;
      end
   end

   // IF/ID register and stall buffer.
   always_ff @(posedge clock) begin
      if (reset) begin
         instr_r     <= NOP_INSTR;
         pc4_r       <= 32'h0000_0000;
         buf_instr_r <= 32'h0000_0000;
         buf_pc4_r   <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_REQ: begin
               if (mc_if_ready) begin
                  if (fw_if_id_stall) begin
                     buf_instr_r <= mc_if_data;
                     buf_pc4_r   <= pc_plus4_s;
                  end else begin
                     instr_r <= mc_if_data;
                     pc4_r   <= pc_plus4_s;
                  end
               end else if (!fw_if_id_stall) begin
                  instr_r <= NOP_INSTR;
                  pc4_r   <= 32'h0000_0000;
               end
            end
            ST_HOLD: begin
               if (!fw_if_id_stall) begin
                  instr_r <= buf_instr_r;
                  pc4_r   <= buf_pc4_r;
               end
            end
            default: begin
               instr_r <= NOP_INSTR;
               pc4_r   <= 32'h0000_0000;
            end
         endcase
      end
   end

   assign if_mc_en        = mc_en_s;
   assign if_mc_addr      = pc_r;
   assign if_id_instrucao = instr_r;
   assign if_id_proximopc = pc4_r;

endmodule
